// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and defaults for the parametrised dual-port RAM
// Purpose: sequencer state enum, read-data source select, default geometry.
// Ports: none (package).
package ram_pkg;

    localparam int RAM_DATA_W_DEF = 8;
    localparam int RAM_DEPTH_DEF  = 64;

    typedef enum logic {
        RAM_CLEAR,
        RAM_READY
    } ram_state_t;

    // Which register feeds rd_data after the last accepted read.
    typedef enum logic [1:0] {
        RD_SRC_ARRAY,
        RD_SRC_FWD,
        RD_SRC_ZERO
    } rd_src_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - bare storage: one synchronous write port, one synchronous read port
// Purpose: plain memory array, no reset, no collision handling.
// Ports:
//   clk             clock
//   we/waddr/wdata  write port, mem[waddr] <= wdata when we
//   re/raddr/rdata  read port, rdata <= mem[raddr] when re, holds otherwise
module ram_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_dual_port_param.sv
// rtl/ram_dual_port_param.sv - parametrised simple-dual-port RAM with registered read
// Purpose: one write and one read per cycle, write-first collision forwarding,
//   out-of-range protection, rd_valid pulse, optional clear-after-reset
//   sequencer enabled by macro RAM_CLEAR_EN.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data     write request
//   rd_en, rd_addr              read request
//   rd_data, rd_valid           registered read data and one-cycle valid pulse
//   busy                        requests are dropped while high (clear running)
module ram_dual_port_param
    import ram_pkg::*;
#(
    parameter  int DATA_W = RAM_DATA_W_DEF,
    parameter  int DEPTH  = RAM_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    // One extra bit so DEPTH itself is representable for the range compare.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic              accept;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic              collide;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] arr_q;
    logic [DATA_W-1:0] fwd_q;
    rd_src_t           rd_src;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
    assign wr_acc      = wr_en & accept & wr_in_range;
    assign rd_acc      = rd_en & accept;
    assign collide     = wr_acc & rd_acc & (wr_addr == rd_addr);

`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RAM_CLEAR;
            clr_addr <= '0;
            busy_q   <= 1'b1;
        end else begin
            case (state)
                RAM_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state  <= RAM_READY;
                        busy_q <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state  <= RAM_READY;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign accept = ~busy_q;
    assign busy   = busy_q;

    // The sweep owns the write port while clearing; user writes are already
    // blocked by accept, so no arbitration is needed.
    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == RAM_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end
    end
`else
    assign accept    = 1'b1;
    assign busy      = 1'b0;
    assign mem_we    = wr_acc;
    assign mem_waddr = wr_addr;
    assign mem_wdata = wr_data;
`endif

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc & rd_in_range),
        .raddr (rd_addr),
        .rdata (arr_q)
    );

    // The array's read register has no reset, so a registered source select
    // (reset to ZERO) picks between it, the forwarded write data and zero.
    // Everything feeding rd_data is a flop, so there is no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_src   <= RD_SRC_ZERO;
            fwd_q    <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                if (!rd_in_range) begin
                    rd_src <= RD_SRC_ZERO;
                end else if (collide) begin
                    rd_src <= RD_SRC_FWD;
                    fwd_q  <= wr_data;
                end else begin
                    rd_src <= RD_SRC_ARRAY;
                end
            end
        end
    end

    always_comb begin
        case (rd_src)
            RD_SRC_ARRAY: rd_data = arr_q;
            RD_SRC_FWD:   rd_data = fwd_q;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_ram_dual_port_param.sv
// tb/tb_ram_dual_port_param.sv - self-checking bench for ram_dual_port_param
module tb_ram_dual_port_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: 8 x 64
    logic       a_wr_en = 0, a_rd_en = 0;
    logic [5:0] a_wr_addr = 0, a_rd_addr = 0;
    logic [7:0] a_wr_data = 0;
    logic [7:0] a_rd_data;
    logic       a_rd_valid, a_busy;

    // Instance B: 16 x 40
    logic        b_wr_en = 0, b_rd_en = 0;
    logic [5:0]  b_wr_addr = 0, b_rd_addr = 0;
    logic [15:0] b_wr_data = 0;
    logic [15:0] b_rd_data;
    logic        b_rd_valid, b_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_busy_cycles;

    always #5 clk = ~clk;

    ram_dual_port_param #(.DATA_W(8), .DEPTH(64)) u_a (
        .clk(clk), .rst(rst),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
    );

    ram_dual_port_param #(.DATA_W(16), .DEPTH(40)) u_b (
        .clk(clk), .rst(rst),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
    );

    // Reference model for instance A: contents plus a "known" flag per word.
    logic [7:0] ma [64];
    bit         ka [64];
    logic [7:0] last_d;
    bit         last_k;

    typedef struct {
        logic       we;
        logic [5:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [5:0] ra;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            ma[i] = 8'h00;
`ifdef RAM_CLEAR_EN
            ka[i] = 1'b1;
`else
            ka[i] = 1'b0;
`endif
        end
    endtask

    // Applies one cycle on instance A; inputs change after the falling edge,
    // outputs are sampled at the next falling edge.
    task automatic cyc_a(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                         input logic re, input logic [5:0] ra);
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
        a_rd_en = re; a_rd_addr = ra;
        if (we) begin
            ma[wa] = wd;
            ka[wa] = 1'b1;
        end
        @(negedge clk);
        a_wr_en = 0; a_rd_en = 0;
    endtask

    task automatic cyc_b(input logic we, input logic [5:0] wa, input logic [15:0] wd,
                         input logic re, input logic [5:0] ra);
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
        b_rd_en = re; b_rd_addr = ra;
        @(negedge clk);
        b_wr_en = 0; b_rd_en = 0;
    endtask

    // Counts busy cycles after reset release, bounded.
    task automatic count_busy(input string name, input bit hold_req);
        int cnt;
        cnt = 0;
        if (hold_req) begin
            a_wr_en = 1; a_wr_addr = 6'd7; a_wr_data = 8'h5A;
            a_rd_en = 1; a_rd_addr = 6'd7;
        end
        while (a_busy && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (hold_req && a_busy) chk({name, "_valid_during_busy"}, a_rd_valid, 0);
        end
        a_wr_en = 0; a_rd_en = 0;
        chk(name, cnt, exp_busy_cycles);
    endtask

    initial begin
        logic       we, re;
        logic [5:0] wa, ra;
        logic [7:0] wd, ed;
        bit         ek;
        logic [15:0] sb [40];

`ifdef RAM_CLEAR_EN
        exp_busy_cycles = 64;
`else
        exp_busy_cycles = 0;
`endif

        tv[0] = '{1, 6'd5,  8'hA5, 0, 6'd0,  0, 8'h00};
        tv[1] = '{0, 6'd0,  8'h00, 1, 6'd5,  1, 8'hA5};
        tv[2] = '{0, 6'd0,  8'h00, 0, 6'd0,  0, 8'hA5};
        tv[3] = '{1, 6'd9,  8'h11, 0, 6'd0,  0, 8'hA5};
        tv[4] = '{1, 6'd9,  8'h3C, 1, 6'd9,  1, 8'h3C};
        tv[5] = '{0, 6'd0,  8'h00, 1, 6'd9,  1, 8'h3C};
        tv[6] = '{1, 6'd63, 8'h7E, 1, 6'd5,  1, 8'hA5};
        tv[7] = '{0, 6'd0,  8'h00, 1, 6'd63, 1, 8'h7E};

        model_reset();

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        chk("rst_rd_data", a_rd_data, 8'h00);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_busy", a_busy, (exp_busy_cycles != 0) ? 1 : 0);
        chk("rst_b_rd_data", b_rd_data, 16'h0);
        rst = 0;
        count_busy("busy_after_reset", 0);

`ifdef RAM_CLEAR_EN
        cyc_a(0, 0, 0, 1, 6'd0);
        chk("clr_rd0_valid", a_rd_valid, 1);
        chk("clr_rd0_data", a_rd_data, 8'h00);
        cyc_a(0, 0, 0, 1, 6'd31);
        chk("clr_rd31_data", a_rd_data, 8'h00);
        cyc_a(0, 0, 0, 1, 6'd63);
        chk("clr_rd63_data", a_rd_data, 8'h00);
        cyc_a(0, 0, 0, 0, 6'd0);
        chk("clr_idle_valid", a_rd_valid, 0);
`endif

        // Table-driven directed vectors.
        for (int i = 0; i < 8; i++) begin
            cyc_a(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra);
            chk($sformatf("vec%0d_valid", i), a_rd_valid, tv[i].ev);
            chk($sformatf("vec%0d_data", i), a_rd_data, tv[i].ed);
        end
        last_d = 8'h7E;
        last_k = 1'b1;

        // Randomised traffic against the model (write-first on collision).
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom);
            wa = 6'($urandom);
            wd = 8'($urandom);
            re = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom);
            ek = 0;
            ed = 8'h00;
            if (re) begin
                if (we && wa == ra) begin
                    ed = wd; ek = 1;
                end else begin
                    ed = ma[ra]; ek = ka[ra];
                end
            end
            cyc_a(we, wa, wd, re, ra);
            chk("rand_valid", a_rd_valid, re);
            if (re) begin
                last_d = ed; last_k = ek;
            end
            if (last_k) chk("rand_data", a_rd_data, last_d);
        end

        // Reset asynchronously in the middle of a cycle.
        #2 rst = 1;
        #1;
        chk("async_rst_valid", a_rd_valid, 0);
        chk("async_rst_data", a_rd_data, 8'h00);
        @(negedge clk);
        rst = 0;
        model_reset();
        repeat (20) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        count_busy("busy_after_midclear_rst", 1);
`ifdef RAM_CLEAR_EN
        cyc_a(0, 0, 0, 1, 6'd7);
        chk("busy_write_dropped", a_rd_data, 8'h00);
`endif

        // Instance B: out-of-range handling on a non-power-of-two depth.
        cyc_b(1, 6'd39, 16'h1234, 0, 0);
        cyc_b(1, 6'd45, 16'hFFFF, 0, 0);
        cyc_b(0, 0, 0, 1, 6'd45);
        chk("oor_valid", b_rd_valid, 1);
        chk("oor_data", b_rd_data, 16'h0000);
        cyc_b(0, 0, 0, 1, 6'd39);
        chk("oor_neighbour", b_rd_data, 16'h1234);
        cyc_b(1, 6'd45, 16'hBEEF, 1, 6'd45);
        chk("oor_collide", b_rd_data, 16'h0000);

        // Streaming: one write per cycle, then one read per cycle.
        for (int i = 0; i < 40; i++) begin
            sb[i] = 16'($urandom);
            cyc_b(1, 6'(i), sb[i], 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            b_rd_en = 1; b_rd_addr = 6'(i);
            @(negedge clk);
            chk("stream_valid", b_rd_valid, 1);
            chk("stream_data", b_rd_data, sb[i]);
        end
        b_rd_en = 0;
        @(negedge clk);
        chk("stream_end_valid", b_rd_valid, 0);
        chk("stream_end_hold", b_rd_data, sb[39]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ram_dual_port_param.md
# ram_dual_port_param

Parametrised simple-dual-port synchronous RAM with one write port and one registered read port, both usable in the same cycle. It generalises the team's 64x8 single-port RAM to arbitrary width and depth and adds a read-valid handshake, write-first collision forwarding and an optional clear-after-reset sequencer. It serves as the generic on-chip storage primitive for buffers and lookup tables in the memories area.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (>= 1)
- DEPTH, 64, number of words (>= 2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data updated this cycle (one-cycle pulse per accepted read)
- busy  out  1  block not accepting requests (clear in progress)

## Operation
- Request accepted when its enable is high at a rising edge and busy is 0. Requests while busy=1 are dropped silently, no queueing.
- Write: ram[wr_addr] <= wr_data on accepting edge.
- Read: rd_data <= ram[rd_addr] on accepting edge, rd_valid <= 1. With no accepted read, rd_valid <= 0 and rd_data holds its previous value.
- Collision (accepted read and write, same address, same edge): write-first; rd_data <= wr_data, array written as usual.
- Out-of-range address (>= DEPTH): write ignored, array unchanged; read returns all-zero data with rd_valid=1.
- Full throughput: one read and one write per cycle, indefinitely.
- State machine (with RAM_CLEAR_EN): CLEAR -> READY.
  - CLEAR: entered on rst; sweeps clr_addr 0..DEPTH-1, writing zero, one word per cycle; busy=1.
  - CLEAR -> READY after the write to DEPTH-1; busy=0 from the following cycle.
  - READY: normal operation; stays until rst.
- Reset mid-operation (including mid-clear): all state returns to reset values immediately; clear restarts from address 0.

## Timing
- Reset values: rd_data=0, rd_valid=0, busy=1 with RAM_CLEAR_EN, busy=0 without; clear address counter=0.
- Read latency: 1 cycle. Read accepted at edge N -> rd_data/rd_valid valid after edge N until edge N+1.
- Write visible to a read accepted at the same edge (collision rule) and to all later reads.
- Clear duration: DEPTH cycles from first edge after rst deasserts; first request accepted at edge DEPTH+1.
- busy is a registered output; no combinational path from any input to any output.

## Configuration
- RAM_CLEAR_EN defined: CLEAR/READY sequencer present, memory zeroed after every reset, busy as above.
- Undefined: no sequencer or counter; busy tied 0; block accepts requests from first edge after reset; array contents undefined until written (rd_data register still resets to 0).

## Structure
- Shared package ram_pkg: state enum ram_state_t {RAM_CLEAR, RAM_READY}; default DATA_W/DEPTH constants.
- Sub-module ram_array: bare storage, one synchronous write port and one synchronous read port, no reset, no collision logic; top level owns the muxing of clear vs. user write, collision forwarding, range checks, rd_valid and the sequencer.

## Test plan
- With RAM_CLEAR_EN, DEPTH=64: release rst -> busy=1 for exactly 64 cycles; then reads of addresses 0, 31, 63 return 0x00 with rd_valid pulse one cycle after each rd_en.
- Write 0xA5 to addr 5, next cycle read addr 5 -> rd_data=0xA5, rd_valid=1 one cycle later; rd_valid=0 the cycle after, rd_data stays 0xA5.
- Same-edge write 0x3C and read on addr 9 (old value 0x11) -> rd_data=0x3C; following read of addr 9 -> 0x3C.
- DEPTH=40: write 0xFF to addr 45, read addr 45 -> rd_data=0x00, rd_valid=1; read addr 39 unaffected.
- Assert rst at clear cycle 20, release -> busy=1 for a full 64 cycles again; wr_en/rd_en during busy ignored (rd_valid stays 0, no array change).
- Streaming: 64 consecutive writes then 64 consecutive reads, DATA_W=16 -> every read returns its written value, rd_valid high for 64 consecutive cycles.
